cp0_intr_unit: RTL and testbench

- Coprocessor-0 / interrupt responder for the MIPS 5-stage pipelined CPU.
- Executes the `cp_oper` requests the pipeline controller issues: MTC0 store, ERET, and MFC0 read via the read port.
- Synchronises and latches the external interrupt line. Tells the controller to redirect the PC through a one-cycle `jump_en` pulse with `jump_addr`.
- Owns the Status, Cause, EPC and handler-base (EHB) registers.

---
 rtl/cp0_intr_unit_if.sv | 25 ++
 rtl/cp0_intr_unit.sv | 116 +++++++++++
 tb/tb_cp0_intr_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_intr_unit_if.sv
// Bus between the pipeline controller and the CP0 interrupt unit.
// The master side is the controller and the slave side is cp0_intr_unit.
interface cp0_intr_unit_if;
  logic [1:0]  cp_oper;
  logic        cp_valid;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [31:0] pc_cur;
  logic        pc_valid;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        in_handler;

  modport master (
    output cp_oper, cp_valid, addr_w, data_w, addr_r, pc_cur, pc_valid,
    input  data_r, jump_en, jump_addr, in_handler
  );

  modport slave (
    input  cp_oper, cp_valid, addr_w, data_w, addr_r, pc_cur, pc_valid,
    output data_r, jump_en, jump_addr, in_handler
  );
endinterface

// File: rtl/cp0_intr_unit.sv
// Coprocessor-0 interrupt responder: holds Status, Cause, EPC and EHB, latches the
// synchronised interrupt line and issues one-cycle PC redirects for interrupts and ERET.
module cp0_intr_unit #(
  parameter logic [31:0] EHB_RESET      = 32'h0000_0180,
  parameter int unsigned IR_SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ir_in,
  cp0_intr_unit_if.slave cp
);

  typedef enum logic {IDLE = 1'b0, HANDLER = 1'b1} state_e;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHB    = 5'd20;

  logic [IR_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                      edge_q, edge_d;
  logic                      ie_q, ie_d;
  logic                      ip_q, ip_d;
  logic [31:0]               epc_q, epc_d;
  logic [31:0]               ehb_q, ehb_d;
  logic                      jump_en_q, jump_en_d;
  logic [31:0]               jump_addr_q, jump_addr_d;
  state_e                    state_q, state_d;
  logic                      rise, eret, mtc0, take;

  // Hardware updates (take, ERET, new edge) are applied after the MTC0 write so they win.
  always_comb begin
    sync_d = {sync_q[IR_SYNC_STAGES-2:0], ir_in};
    edge_d = sync_q[IR_SYNC_STAGES-1];
    rise   = sync_q[IR_SYNC_STAGES-1] & ~edge_q;
    eret   = cp.cp_valid & (cp.cp_oper == 2'b10);
    mtc0   = cp.cp_valid & (cp.cp_oper == 2'b01);
    take   = (state_q == IDLE) & ip_q & ie_q & cp.pc_valid & ~eret & ~jump_en_q;

    ie_d        = ie_q;
    ip_d        = ip_q;
    epc_d       = epc_q;
    ehb_d       = ehb_q;
    state_d     = state_q;
    jump_en_d   = 1'b0;
    jump_addr_d = jump_addr_q;

    if (mtc0) begin
      case (cp.addr_w)
        REG_STATUS: ie_d  = cp.data_w[0];
        REG_CAUSE:  ip_d  = cp.data_w[8];
        REG_EPC:    epc_d = cp.data_w;
        REG_EHB:    ehb_d = {cp.data_w[31:2], 2'b00};
        default:    ;
      endcase
    end

    if (take) begin
      epc_d       = cp.pc_cur;
      ie_d        = 1'b0;
      ip_d        = 1'b0;
      state_d     = HANDLER;
      jump_en_d   = 1'b1;
      jump_addr_d = ehb_q;
    end else if (eret) begin
      ie_d        = 1'b1;
      state_d     = IDLE;
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end

    if (rise) begin
      ip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      edge_q      <= 1'b0;
      ie_q        <= 1'b0;
      ip_q        <= 1'b0;
      epc_q       <= '0;
      ehb_q       <= EHB_RESET;
      state_q     <= IDLE;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      ie_q        <= ie_d;
      ip_q        <= ip_d;
      epc_q       <= epc_d;
      ehb_q       <= ehb_d;
      state_q     <= state_d;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  always_comb begin
    cp.data_r = '0;
    case (cp.addr_r)
      REG_STATUS: cp.data_r = {31'b0, ie_q};
      REG_CAUSE:  cp.data_r = {23'b0, ip_q, 8'b0};
      REG_EPC:    cp.data_r = epc_q;
      REG_EHB:    cp.data_r = ehb_q;
      default:    cp.data_r = '0;
    endcase
  end

  assign cp.jump_en    = jump_en_q;
  assign cp.jump_addr  = jump_addr_q;
  assign cp.in_handler = (state_q == HANDLER);

endmodule

// File: tb/tb_cp0_intr_unit.sv
// Self-checking bench for cp0_intr_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the CP0 rules.
module tb_cp0_intr_unit;

  localparam int          SYNC     = 2;
  localparam logic [31:0] EHB_INIT = 32'h0000_0180;

  logic clk = 1'b0;
  logic rst;
  logic ir_in;

  cp0_intr_unit_if cp();

  cp0_intr_unit #(
    .EHB_RESET      (EHB_INIT),
    .IR_SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ir_in (ir_in),
    .cp    (cp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] pc_lvl = 32'h0;
  bit          pv_lvl = 1'b0;
  bit          ir_lvl = 1'b0;

  bit          m_valid = 1'b0;
  bit          m_ie, m_ip, m_handler, m_jump;
  logic [31:0] m_epc, m_ehb, m_jaddr;
  bit          m_seen [SYNC+1];
  bit          prev_jump = 1'b0;

  bit          r_rst, r_v;
  logic [1:0]  r_op;
  logic [4:0]  r_aw, r_ar;
  logic [31:0] r_dw;
  int          wait_n;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd12:   return {31'b0, m_ie};
      5'd13:   return m_ip ? 32'h0000_0100 : 32'h0;
      5'd14:   return m_epc;
      5'd20:   return m_ehb;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the CP0 rules; m_seen[k] is the interrupt line as sampled k edges ago.
  task automatic modelStep(input bit r, input bit v, input logic [1:0] op,
                           input logic [4:0] aw, input logic [31:0] dw);
    bit          eret, mtc, take, rise;
    bit          n_ie, n_ip;
    logic [31:0] n_epc, n_ehb;
    if (r) begin
      m_valid = 1'b1;
      m_ie = 0; m_ip = 0; m_handler = 0; m_jump = 0;
      m_epc = 0; m_ehb = EHB_INIT; m_jaddr = 0;
      for (int k = 0; k <= SYNC; k++) m_seen[k] = 1'b0;
      return;
    end
    eret = v && (op == 2'b10);
    mtc  = v && (op == 2'b01);
    rise = m_seen[SYNC-1] && !m_seen[SYNC];
    take = !m_handler && m_ip && m_ie && pv_lvl && !eret && !m_jump;
    n_ie = m_ie; n_ip = m_ip; n_epc = m_epc; n_ehb = m_ehb;
    if (mtc) begin
      if (aw == 5'd12) n_ie  = dw[0];
      if (aw == 5'd13) n_ip  = dw[8];
      if (aw == 5'd14) n_epc = dw;
      if (aw == 5'd20) n_ehb = dw & 32'hFFFF_FFFC;
    end
    if (take) begin n_epc = pc_lvl; n_ie = 0; n_ip = 0; end
    if (eret) n_ie = 1;
    if (rise) n_ip = 1;
    m_jaddr   = take ? m_ehb : (eret ? m_epc : m_jaddr);
    m_jump    = take || eret;
    m_handler = eret ? 1'b0 : (take ? 1'b1 : m_handler);
    m_ie = n_ie; m_ip = n_ip; m_epc = n_epc; m_ehb = n_ehb;
    for (int k = SYNC; k > 0; k--) m_seen[k] = m_seen[k-1];
    m_seen[0] = ir_lvl;
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] op,
                               input logic [4:0] aw, input logic [31:0] dw, input logic [4:0] ar);
    rst = r; cp.cp_valid = v; cp.cp_oper = op; cp.addr_w = aw; cp.data_w = dw;
    cp.addr_r = ar; cp.pc_cur = pc_lvl; cp.pc_valid = pv_lvl; ir_in = ir_lvl;
    @(negedge clk);
    if (m_valid) begin
      checkOutput("data_r",       cp.data_r, modelRead(ar));
      checkOutput("jump_en",      {31'b0, cp.jump_en}, {31'b0, m_jump});
      checkOutput("jump_addr",    cp.jump_addr, m_jaddr);
      checkOutput("in_handler",   {31'b0, cp.in_handler}, {31'b0, m_handler});
      checkOutput("no_back2back", {31'b0, cp.jump_en & prev_jump}, 32'h0);
    end
    prev_jump = cp.jump_en;
    modelStep(r, v, op, aw, dw);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 5'd13);
  endtask

  task automatic writeCp0(input logic [4:0] aw, input logic [31:0] dw);
    applyStimulus(1'b0, 1'b1, 2'b01, aw, dw, aw);
  endtask

  task automatic issueEret();
    applyStimulus(1'b0, 1'b1, 2'b10, 5'd0, 32'h0, 5'd14);
  endtask

  task automatic pulseIrq();
    ir_lvl = 1'b1;
    idleCycles(1);
    ir_lvl = 1'b0;
  endtask

  task automatic peekReg(input string tag, input logic [4:0] ar, input logic [31:0] exp);
    cp.addr_r = ar;
    #1;
    checkOutput(tag, cp.data_r, exp);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd20);
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd20);
    idleCycles(1);
    peekReg("reset_ehb", 5'd20, 32'h0000_0180);
    peekReg("reset_status", 5'd12, 32'h0);
    checkOutput("reset_jump_en", {31'b0, cp.jump_en}, 32'h0);
    checkOutput("reset_in_handler", {31'b0, cp.in_handler}, 32'h0);

    // Enabled interrupt: edge crosses the synchroniser, sets IP, then redirects.
    writeCp0(5'd12, 32'h1);
    writeCp0(5'd20, 32'h0000_0400);
    pc_lvl = 32'h0000_0040; pv_lvl = 1'b1; ir_lvl = 1'b1;
    wait_n = 11;
    for (int i = 1; i <= 10; i++) begin
      idleCycles(1);
      if (cp.jump_en === 1'b1) begin
        wait_n = i;
        break;
      end
    end
    checkOutput("take_latency", 32'(wait_n), 32'd4);
    checkOutput("take_addr", cp.jump_addr, 32'h0000_0400);
    checkOutput("take_handler", {31'b0, cp.in_handler}, 32'h1);
    ir_lvl = 1'b0;
    idleCycles(1);
    checkOutput("take_pulse_width", {31'b0, cp.jump_en}, 32'h0);
    peekReg("take_epc", 5'd14, 32'h0000_0040);
    peekReg("take_ie", 5'd12, 32'h0);

    writeCp0(5'd14, 32'h0000_0044);
    issueEret();
    checkOutput("eret_jump_en", {31'b0, cp.jump_en}, 32'h1);
    checkOutput("eret_addr", cp.jump_addr, 32'h0000_0044);
    checkOutput("eret_handler", {31'b0, cp.in_handler}, 32'h0);
    peekReg("eret_ie", 5'd12, 32'h1);

    // Masked interrupt stays pending until IE is set.
    writeCp0(5'd12, 32'h0);
    pc_lvl = 32'h0000_0048;
    pulseIrq();
    idleCycles(4);
    peekReg("masked_ip", 5'd13, 32'h0000_0100);
    writeCp0(5'd12, 32'h1);
    checkOutput("unmask_same_cycle", {31'b0, cp.jump_en}, 32'h0);
    idleCycles(1);
    checkOutput("unmask_take", {31'b0, cp.jump_en}, 32'h1);
    checkOutput("unmask_addr", cp.jump_addr, 32'h0000_0400);
    idleCycles(1);
    issueEret();
    checkOutput("eret2_addr", cp.jump_addr, 32'h0000_0048);
    idleCycles(1);

    // Pending with pc_valid low, then ERET and take contend.
    pv_lvl = 1'b0;
    pulseIrq();
    idleCycles(4);
    checkOutput("pcv_deferred", {31'b0, cp.jump_en}, 32'h0);
    peekReg("pcv_ip", 5'd13, 32'h0000_0100);
    pv_lvl = 1'b1;
    issueEret();
    checkOutput("race_eret_wins", cp.jump_addr, 32'h0000_0048);
    peekReg("race_ip_kept", 5'd13, 32'h0000_0100);
    idleCycles(1);
    checkOutput("race_gap", {31'b0, cp.jump_en}, 32'h0);
    idleCycles(1);
    checkOutput("race_take", {31'b0, cp.jump_en}, 32'h1);
    checkOutput("race_take_addr", cp.jump_addr, 32'h0000_0400);

    // Software clears the pending bit before it can be taken.
    idleCycles(1);
    issueEret();
    idleCycles(1);
    pv_lvl = 1'b0;
    pulseIrq();
    idleCycles(4);
    writeCp0(5'd13, 32'h0);
    pv_lvl = 1'b1;
    idleCycles(3);
    checkOutput("clear_no_take", {31'b0, cp.jump_en}, 32'h0);
    checkOutput("clear_handler", {31'b0, cp.in_handler}, 32'h0);
    peekReg("clear_ip", 5'd13, 32'h0);

    // Reset lands on the cycle a take would happen.
    pv_lvl = 1'b0;
    pulseIrq();
    idleCycles(4);
    pv_lvl = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 5'd14);
    checkOutput("rst_take_jump", {31'b0, cp.jump_en}, 32'h0);
    peekReg("rst_take_epc", 5'd14, 32'h0);
    idleCycles(1);

    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r_op = 2'b00;
        4, 5, 6:    r_op = 2'b01;
        7:          r_op = 2'b10;
        default:    r_op = 2'b11;
      endcase
      if (r_v && r_op == 2'b10 && m_jump) r_op = 2'b00;
      case ($urandom_range(0, 4))
        0:       r_aw = 5'd12;
        1:       r_aw = 5'd13;
        2:       r_aw = 5'd14;
        3:       r_aw = 5'd20;
        default: r_aw = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 4))
        0:       r_ar = 5'd12;
        1:       r_ar = 5'd13;
        2:       r_ar = 5'd14;
        3:       r_ar = 5'd20;
        default: r_ar = 5'($urandom_range(0, 31));
      endcase
      r_dw   = $urandom;
      pc_lvl = $urandom;
      pv_lvl = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) ir_lvl = ~ir_lvl;
      applyStimulus(r_rst, r_v, r_op, r_aw, r_dw, r_ar);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
